axi_master_arbiter: RTL and testbench



---
 rtl/axi_master_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_arbiter.sv
// rtl/axi_master_arbiter.sv - two-master AXI4 arbiter, LSU fixed priority, grant held per transaction
//
// Shares one AXI4 master port (s_*) between the IFU (m0, read only) and the
// LSU (m1, read and write). The owner is chosen in IDLE, with the LSU
// winning ties. The grant is held until the owner's read (rlast beat) or
// write (B handshake) completes, then the arbiter spends one cycle in IDLE.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   m0_req, m1_req      level requests, held until the transaction completes
//   m0_ar*/m0_r*        IFU read address / read data channels
//   m1_ar*/m1_r*        LSU read address / read data channels
//   m1_aw*/m1_w*/m1_b*  LSU write address / write data / write response
//   s_*                 full AXI4 master port toward the interconnect
//   grant               one-hot owner: 01 IFU, 10 LSU, 00 idle
//   resp_err            sticky, set by any granted R or B beat with resp != OKAY
module axi_master_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [3:0]        m0_rid,
  input  logic              m0_rready,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [3:0]        m1_rid,
  input  logic              m1_rready,
  input  logic              m1_awvalid,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [3:0]        m1_awid,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  output logic              m1_awready,
  input  logic              m1_wvalid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_wready,
  output logic              m1_bvalid,
  output logic [1:0]        m1_bresp,
  output logic [3:0]        m1_bid,
  input  logic              m1_bready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [3:0]        s_rid,
  output logic              s_rready,
  output logic              s_awvalid,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [3:0]        s_awid,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  input  logic              s_awready,
  output logic              s_wvalid,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_wlast,
  input  logic              s_wready,
  input  logic              s_bvalid,
  input  logic [1:0]        s_bresp,
  input  logic [3:0]        s_bid,
  output logic              s_bready,
  output logic [1:0]        grant,
  output logic              resp_err
);

  typedef enum logic [1:0] {IDLE, G_IFU, G_LSU} state_t;

  state_t state;
  state_t state_next;
  logic   ifu_sel;

  // Payloads are plain muxes; only the valid/ready handshakes are gated.
  assign ifu_sel   = (state == G_IFU);
  assign s_araddr  = ifu_sel ? m0_araddr  : m1_araddr;
  assign s_arid    = ifu_sel ? m0_arid    : m1_arid;
  assign s_arlen   = ifu_sel ? m0_arlen   : m1_arlen;
  assign s_arsize  = ifu_sel ? m0_arsize  : m1_arsize;
  assign s_arburst = ifu_sel ? m0_arburst : m1_arburst;

  assign s_awaddr  = m1_awaddr;
  assign s_awid    = m1_awid;
  assign s_awlen   = m1_awlen;
  assign s_awsize  = m1_awsize;
  assign s_awburst = m1_awburst;
  assign s_wdata   = m1_wdata;
  assign s_wstrb   = m1_wstrb;
  assign s_wlast   = m1_wlast;

  assign m0_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m0_rid    = s_rid;
  assign m1_rdata  = s_rdata;
  assign m1_rresp  = s_rresp;
  assign m1_rlast  = s_rlast;
  assign m1_rid    = s_rid;
  assign m1_bresp  = s_bresp;
  assign m1_bid    = s_bid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Completion is decoded from the owning master's ready rather than from
  // s_rready/s_bready so this block has no path through its own outputs.
  always_comb begin
    state_next = state;
    grant      = 2'b00;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (m1_req)      state_next = G_LSU;
        else if (m0_req) state_next = G_IFU;
      end
      G_IFU: begin
        grant      = 2'b01;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
        if (s_rvalid && m0_rready && s_rlast) state_next = IDLE;
      end
      G_LSU: begin
        grant      = 2'b10;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
        s_awvalid  = m1_awvalid;
        m1_awready = s_awready;
        s_wvalid   = m1_wvalid;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
        if ((s_rvalid && m1_rready && s_rlast) || (s_bvalid && m1_bready)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if ((s_rvalid && s_rready && (s_rresp != 2'b00)) ||
                 (s_bvalid && s_bready && (s_bresp != 2'b00))) begin
      resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb/tb_axi_master_arbiter.sv - self-checking bench for axi_master_arbiter
module tb_axi_master_arbiter;

  logic        clock, reset, m0_req, m1_req;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_awid, m1_wstrb, m1_bid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst, m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_wstrb, s_bid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;
  logic [1:0]  grant;
  logic        resp_err;

  int checks = 0;
  int failures = 0;

  axi_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .m0_req(m0_req), .m1_req(m1_req),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rid(m0_rid), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rid(m1_rid), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_bready(s_bready), .grant(grant), .resp_err(resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Owner rule: LSU if it requests, otherwise IFU if it requests.
  function automatic logic [1:0] pick(input bit r0, input bit r1);
    if (r1) return 2'b10;
    if (r0) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m1_req = 0;
    m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0; m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = 0; m1_awid = 0; m1_awlen = 0; m1_awsize = 0; m1_awburst = 0;
    m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;
  endtask

  // Plays both the granted master and the slave for one read; counts protocol
  // deviations in errs. Entered one cycle after the grant is expected.
  task automatic do_read(input bit m, input logic [31:0] addr, input logic [31:0] d0,
                         input logic [7:0] len, input int lat, input logic [1:0] resp,
                         output int errs);
    logic [3:0]  id;
    logic [31:0] exp_q[$];
    logic [31:0] exp_d;
    logic [1:0]  own;
    logic        last;
    int          n;
    errs = 0;
    own = m ? 2'b10 : 2'b01;
    id = 4'($urandom_range(0, 15));
    if (m) begin
      m1_arvalid = 1; m1_araddr = addr; m1_arid = id; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'b01;
    end else begin
      m0_arvalid = 1; m0_araddr = addr; m0_arid = id; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'b01;
    end
    s_arready = 1;
    #1;
    n = 0;
    while (s_arvalid !== 1'b1 && n < 20) begin step(); n++; end
    if (n != 0) errs++;
    if (s_araddr !== addr || s_arid !== id || s_arlen !== len || s_arsize !== 3'd2 || s_arburst !== 2'b01) errs++;
    if ((m ? m1_arready : m0_arready) !== 1'b1 || (m ? m0_arready : m1_arready) !== 1'b0) errs++;
    step();
    m0_arvalid = 0; m1_arvalid = 0; s_arready = 0;
    repeat (lat) begin
      #1;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || grant !== own) errs++;
      step();
    end
    if (m) m1_rready = 1; else m0_rready = 1;
    for (int b = 0; b <= int'(len); b++) begin
      last = (b == int'(len));
      s_rvalid = 1; s_rdata = (b == 0) ? d0 : $urandom; s_rid = id; s_rresp = resp; s_rlast = last;
      exp_q.push_back(s_rdata);
      #1;
      exp_d = exp_q.pop_front();
      if (m) begin
        if (m1_rvalid !== 1'b1 || m1_rdata !== exp_d || m1_rid !== id || m1_rlast !== last ||
            m1_rresp !== resp || m0_rvalid !== 1'b0) errs++;
      end else begin
        if (m0_rvalid !== 1'b1 || m0_rdata !== exp_d || m0_rid !== id || m0_rlast !== last ||
            m0_rresp !== resp || m1_rvalid !== 1'b0) errs++;
        if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || s_bready !== 1'b0 ||
            m1_awready !== 1'b0 || m1_wready !== 1'b0 || m1_arready !== 1'b0) errs++;
      end
      if (s_rready !== 1'b1 || grant !== own) errs++;
      step();
    end
    s_rvalid = 0; s_rlast = 0; s_rresp = 0; m0_rready = 0; m1_rready = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, output int errs);
    logic [3:0] id;
    int         n;
    errs = 0;
    id = 4'($urandom_range(0, 15));
    m1_awvalid = 1; m1_awaddr = addr; m1_awid = id; m1_awlen = 0; m1_awsize = 3'd2; m1_awburst = 2'b01;
    m1_wvalid = 1; m1_wdata = data; m1_wstrb = strb; m1_wlast = 1;
    s_awready = 1; s_wready = 1;
    #1;
    n = 0;
    while (s_awvalid !== 1'b1 && n < 20) begin step(); n++; end
    if (n != 0) errs++;
    if (s_awaddr !== addr || s_awid !== id || s_awlen !== 8'd0 || s_awsize !== 3'd2 || s_awburst !== 2'b01 ||
        s_wvalid !== 1'b1 || s_wdata !== data || s_wstrb !== strb || s_wlast !== 1'b1) errs++;
    if (m1_awready !== 1'b1 || m1_wready !== 1'b1 || m0_rvalid !== 1'b0 || m0_arready !== 1'b0 ||
        s_arvalid !== 1'b0) errs++;
    step();
    m1_awvalid = 0; m1_wvalid = 0; m1_wlast = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = resp; s_bid = id; m1_bready = 1;
    #1;
    if (m1_bvalid !== 1'b1 || m1_bresp !== resp || m1_bid !== id || s_bready !== 1'b1 ||
        m0_rvalid !== 1'b0 || grant !== 2'b10) errs++;
    step();
    s_bvalid = 0; s_bresp = 0; m1_bready = 0;
  endtask

  task automatic test_reset();
    m0_req = 1; m1_req = 1; m0_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1; s_rvalid = 1; s_bvalid = 1;
    m0_rready = 1; m1_bready = 1;
    step();
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++;
    if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    checks++;
    if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 5'b0)
      begin failures++; $display("FAIL reset_slave_handshakes got=%b exp=00000", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}); end
    checks++;
    if ({m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid} !== 7'b0)
      begin failures++; $display("FAIL reset_master_handshakes got=%b exp=0000000",
        {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}); end
    clear_inputs();
    reset = 0;
    step();
  endtask

  task automatic test_ifu_only();
    int errs;
    m0_req = 1;
    #1;
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL ifu_pre_grant got=%b exp=00", grant); end
    step();
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL ifu_grant got=%b exp=01", grant); end
    do_read(0, 32'h8000_0000, 32'h0000_0013, 8'd0, 3, 2'b00, errs);
    m0_req = 0;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL ifu_read errors=%0d exp=0", errs); end
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL ifu_release got=%b exp=00", grant); end
    step();
  endtask

  task automatic test_simultaneous();
    int errs;
    m0_req = 1; m1_req = 1;
    step();
    checks++;
    if (grant !== pick(1, 1)) begin failures++; $display("FAIL simul_first got=%b exp=%b", grant, pick(1, 1)); end
    do_read(1, $urandom, $urandom, 8'd1, 1, 2'b00, errs);
    m1_req = 0;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL simul_lsu_read errors=%0d exp=0", errs); end
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL simul_dead_cycle got=%b exp=00", grant); end
    step();
    checks++;
    if (grant !== pick(1, 0)) begin failures++; $display("FAIL simul_second got=%b exp=%b", grant, pick(1, 0)); end
    do_read(0, $urandom, $urandom, 8'd0, 0, 2'b00, errs);
    m0_req = 0;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL simul_ifu_read errors=%0d exp=0", errs); end
    step();
  endtask

  task automatic test_lsu_store();
    int errs;
    m1_req = 1;
    step();
    checks++;
    if (grant !== 2'b10) begin failures++; $display("FAIL store_grant got=%b exp=10", grant); end
    do_write(32'ha000_03f8, 32'h0000_0041, 4'b0001, 2'b00, errs);
    m1_req = 0;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL store_write errors=%0d exp=0", errs); end
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL store_release got=%b exp=00", grant); end
    checks++;
    if (resp_err !== 1'b0) begin failures++; $display("FAIL store_resp_err got=%b exp=0", resp_err); end
    step();
  endtask

  // LSU wants to write while the IFU burst is in flight; it must wait for rlast.
  task automatic test_burst();
    int errs;
    m0_req = 1;
    step();
    m1_req = 1; m1_awvalid = 1; m1_wvalid = 1;
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL burst_grant got=%b exp=01", grant); end
    do_read(0, $urandom, $urandom, 8'd3, 2, 2'b00, errs);
    m0_req = 0;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL burst_read errors=%0d exp=0", errs); end
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL burst_release got=%b exp=00", grant); end
    step();
    checks++;
    if (grant !== 2'b10) begin failures++; $display("FAIL burst_lsu_next got=%b exp=10", grant); end
    do_write($urandom, $urandom, 4'($urandom_range(0, 15)), 2'b00, errs);
    m1_req = 0;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL burst_lsu_write errors=%0d exp=0", errs); end
    step();
  endtask

  task automatic test_random();
    bit         p0, p1, wr;
    logic [1:0] exp_g, resp;
    logic       exp_err;
    int         errs;
    exp_err = 1'b0;
    for (int it = 0; it < 12; it++) begin
      p0 = 1'($urandom_range(0, 1));
      p1 = 1'($urandom_range(0, 1));
      if (!p0 && !p1) p0 = 1;
      m0_req = p0; m1_req = p1;
      while (p0 || p1) begin
        exp_g = pick(p0, p1);
        #1;
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL rand_idle it=%0d got=%b exp=00", it, grant); end
        step();
        checks++;
        if (grant !== exp_g) begin failures++; $display("FAIL rand_grant it=%0d got=%b exp=%b", it, grant, exp_g); end
        resp = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
        if (resp != 2'b00) exp_err = 1'b1;
        wr = 1'($urandom_range(0, 1));
        if (exp_g == 2'b10 && wr)
          do_write($urandom, $urandom, 4'($urandom_range(0, 15)), resp, errs);
        else
          do_read(exp_g == 2'b10, $urandom, $urandom, 8'($urandom_range(0, 3)), $urandom_range(0, 2), resp, errs);
        checks++;
        if (errs !== 0) begin failures++; $display("FAIL rand_xfer it=%0d errors=%0d exp=0", it, errs); end
        if (exp_g == 2'b10) begin p1 = 0; m1_req = 0; end
        else begin p0 = 0; m0_req = 0; end
      end
      checks++;
      if (resp_err !== exp_err) begin failures++; $display("FAIL rand_resp_err it=%0d got=%b exp=%b", it, resp_err, exp_err); end
      step();
    end
  endtask

  task automatic test_error_reset();
    int errs;
    m1_req = 1;
    step();
    do_read(1, $urandom, $urandom, 8'd0, 1, 2'b10, errs);
    m1_req = 0;
    checks++;
    if (errs !== 0) begin failures++; $display("FAIL err_lsu_read errors=%0d exp=0", errs); end
    checks++;
    if (resp_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", resp_err); end
    step();
    m0_req = 1;
    step();
    do_read(0, $urandom, $urandom, 8'd1, 0, 2'b00, errs);
    m0_req = 0;
    checks++;
    if (resp_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", resp_err); end
    step();
    m0_req = 1;
    step();
    m0_arvalid = 1; s_arready = 1;
    step();
    s_rvalid = 1; s_rlast = 0; s_rresp = 2'b10; m0_rready = 1;
    #1;
    checks++;
    if (m0_rvalid !== 1'b1 || grant !== 2'b01)
      begin failures++; $display("FAIL rst_pre_state rvalid=%b grant=%b exp rvalid=1 grant=01", m0_rvalid, grant); end
    #2;
    reset = 1;
    #1;
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL rst_async_grant got=%b exp=00", grant); end
    checks++;
    if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_async_resp_err got=%b exp=0", resp_err); end
    checks++;
    if ({s_arvalid, s_rready, m0_rvalid, m0_arready} !== 4'b0)
      begin failures++; $display("FAIL rst_async_valids got=%b exp=0000", {s_arvalid, s_rready, m0_rvalid, m0_arready}); end
    clear_inputs();
    step();
    reset = 0;
    step();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    step();
    test_reset();
    test_ifu_only();
    test_simultaneous();
    test_lsu_store();
    test_burst();
    test_random();
    test_error_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
